// File: rtl/instr_loader.sv
// instr_loader: boot-time instruction-memory writer.
// Takes a little-endian byte stream (LEN_LO, LEN_HI, then 4*N data bytes) and writes
// 32-bit words to instruction memory from address 0. It holds the core in reset until
// the whole image has been written.
// Optional feature: define INSTR_LOADER_CSUM_EN to require a trailing XOR checksum byte.
module instr_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_core_rst,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [2:0] StLen0  = 3'd0;
  localparam logic [2:0] StLen1  = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StWrite = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;
  localparam logic [2:0] StErr   = 3'd5;
`ifdef INSTR_LOADER_CSUM_EN
  localparam logic [2:0] StCsum  = 3'd6;
`endif

  // The largest legal word count is the full memory size.
  localparam logic [16:0]     Cap    = 17'd1 << ADDR_W;
  localparam logic [ADDR_W:0] CntOne = 1;

  logic [2:0]        r_state;
  logic [15:0]       r_len;
  logic [1:0]        r_byte_idx;
  // One bit wider than the address so a full-memory image can be counted.
  logic [ADDR_W:0]   r_word_cnt;
  logic [31:0]       r_word;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_core_rst;
  logic              r_done;
  logic              r_err;
`ifdef INSTR_LOADER_CSUM_EN
  logic [7:0]        r_csum;
`endif

  logic        w_xfer;
  logic [15:0] w_len_new;
  logic        w_oversize;
  logic        w_last;
  logic [31:0] w_word_asm;

  assign w_xfer     = i_rx_valid & o_rx_ready;
  assign w_len_new  = {i_rx_data, r_len[7:0]};
  assign w_oversize = {1'b0, w_len_new} > Cap;
  assign w_last     = (17'(r_word_cnt) == ({1'b0, r_len} - 17'd1));

  // Ready only in byte-consuming states; stalls the source during WRITE.
  always_comb begin
    o_rx_ready = 1'b0;
    case (r_state)
      StLen0, StLen1, StData: o_rx_ready = 1'b1;
`ifdef INSTR_LOADER_CSUM_EN
      StCsum:                 o_rx_ready = 1'b1;
`endif
      default:                o_rx_ready = 1'b0;
    endcase
  end

  // Drop the incoming byte into its lane of the word being assembled.
  always_comb begin
    w_word_asm = r_word;
    w_word_asm[{r_byte_idx, 3'b000} +: 8] = i_rx_data;
  end

  // Load FSM with registered memory-port and status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StLen0;
      r_len       <= '0;
      r_byte_idx  <= '0;
      r_word_cnt  <= '0;
      r_word      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_core_rst  <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef INSTR_LOADER_CSUM_EN
      r_csum      <= '0;
`endif
    end else if (i_start) begin
      // Restart wins over any byte offered in the same cycle.
      r_state    <= StLen0;
      r_len      <= '0;
      r_byte_idx <= '0;
      r_word_cnt <= '0;
      r_word     <= '0;
      r_mem_we   <= 1'b0;
      r_core_rst <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
`ifdef INSTR_LOADER_CSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        StLen0: begin
          if (w_xfer) begin
            r_len[7:0] <= i_rx_data;
            r_state    <= StLen1;
          end
        end
        StLen1: begin
          if (w_xfer) begin
            r_len[15:8] <= i_rx_data;
            if (w_len_new == 16'd0) begin
`ifdef INSTR_LOADER_CSUM_EN
              r_state    <= StCsum;
`else
              r_state    <= StDone;
              r_done     <= 1'b1;
              r_core_rst <= 1'b0;
`endif
            end else if (w_oversize) begin
              r_state <= StErr;
              r_err   <= 1'b1;
            end else begin
              r_state    <= StData;
              r_byte_idx <= '0;
              r_word_cnt <= '0;
              r_word     <= '0;
            end
          end
        end
        StData: begin
          if (w_xfer) begin
            r_word     <= w_word_asm;
            r_byte_idx <= r_byte_idx + 2'd1;
`ifdef INSTR_LOADER_CSUM_EN
            r_csum     <= r_csum ^ i_rx_data;
`endif
            if (r_byte_idx == 2'd3) begin
              r_state     <= StWrite;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_word_cnt[ADDR_W-1:0];
              r_mem_wdata <= w_word_asm;
            end
          end
        end
        StWrite: begin
          if (w_last) begin
`ifdef INSTR_LOADER_CSUM_EN
            r_state    <= StCsum;
`else
            r_state    <= StDone;
            r_done     <= 1'b1;
            r_core_rst <= 1'b0;
`endif
          end else begin
            r_word_cnt <= r_word_cnt + CntOne;
            r_state    <= StData;
          end
        end
`ifdef INSTR_LOADER_CSUM_EN
        StCsum: begin
          if (w_xfer) begin
            if (i_rx_data == r_csum) begin
              r_state    <= StDone;
              r_done     <= 1'b1;
              r_core_rst <= 1'b0;
            end else begin
              r_state <= StErr;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        StDone, StErr: r_state <= r_state;
        default:       r_state <= StLen0;
      endcase
    end
  end

  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_core_rst  = r_core_rst;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: random and directed images checked against a byte-level
// model of the image format (word list, final status, status timing).
module tb_instr_loader;

  localparam int unsigned AW = 8;
  localparam int Cap = 1 << AW;
`ifdef INSTR_LOADER_CSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif

  typedef logic [7:0] byte_q_t[$];

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_rst;
  logic          done;
  logic          err;

  instr_loader #(.ADDR_W(AW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .o_rx_ready  (rx_ready),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_core_rst  (core_rst),
    .o_done      (done),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed write port activity and first done/err cycle.
  logic [AW-1:0] obs_addr[$];
  logic [31:0]   obs_data[$];
  bit            prev_we = 1'b0;
  bit            dbl = 1'b0;
  bit            end_seen = 1'b0;
  int            end_cyc = 0;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      obs_addr.push_back(mem_addr);
      obs_data.push_back(mem_wdata);
      if (prev_we) dbl = 1'b1;
    end
    prev_we = (mem_we === 1'b1);
    if (((done === 1'b1) || (err === 1'b1)) && !end_seen) begin
      end_seen = 1'b1;
      end_cyc  = cyc;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  function automatic byte_q_t make_image(input int n);
    byte_q_t q;
    logic [15:0] nn;
    nn = 16'(n);
    q.push_back(nn[7:0]);
    q.push_back(nn[15:8]);
    if (n <= Cap) begin
      for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
    end
    return q;
  endfunction

  task automatic pulse_start(input bit with_byte);
    @(negedge clk);
    start    = 1'b1;
    rx_valid = with_byte;
    rx_data  = 8'hFF;
    @(posedge clk);
    #1;
    obs_addr.delete();
    obs_data.delete();
    dbl      = 1'b0;
    end_seen = 1'b0;
    @(negedge clk);
    start    = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input byte_q_t q, input int gap_pct, input bit toggle);
    for (int i = 0; i < q.size(); i++) begin
      bit acc;
      acc = 1'b0;
      if (toggle || ($urandom_range(99) < gap_pct)) begin
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(posedge clk);
      end
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = q[i];
      for (int t = 0; t < 40 && !acc; t++) begin
        if (t > 0) @(negedge clk);
        acc = rx_ready;
        @(posedge clk);
      end
      #1;
      last_acc_cyc = cyc;
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL byte_accept: byte %0d not accepted, rx_ready=%b, required 1", i, rx_ready);
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_end();
    for (int t = 0; t < 30 && !((done === 1'b1) || (err === 1'b1)); t++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  // Full image scenario: model derives the write list and final status from the bytes.
  task automatic test_image(input string name, input byte_q_t img, input int gap_pct,
                            input bit toggle, input bit csum_bad);
    byte_q_t     q;
    int          n;
    int          exp_nw;
    int          exp_end;
    bit          over;
    bit          exp_err;
    logic [7:0]  x;
    logic [31:0] w;
    q    = img;
    n    = int'({img[1], img[0]});
    over = (n > Cap);
    x    = 8'h00;
    for (int i = 2; i < img.size(); i++) x ^= img[i];
    if (CsumEn && !over) q.push_back(x ^ {7'd0, csum_bad});
    exp_err = over || (CsumEn && csum_bad);
    exp_nw  = over ? 0 : n;

    pulse_start(1'b0);
    send_bytes(q, gap_pct, toggle);
    wait_end();

    checks++;
    if (obs_addr.size() != exp_nw) begin
      errors++;
      $display("FAIL %s write_count: got %0d, required %0d", name, obs_addr.size(), exp_nw);
    end
    for (int i = 0; i < exp_nw && i < obs_addr.size(); i++) begin
      w = {img[2 + 4 * i + 3], img[2 + 4 * i + 2], img[2 + 4 * i + 1], img[2 + 4 * i]};
      checks++;
      if (obs_addr[i] !== AW'(i) || obs_data[i] !== w) begin
        errors++;
        $display("FAIL %s write_%0d: got addr %0d data %h, required addr %0d data %h",
                 name, i, obs_addr[i], obs_data[i], i, w);
      end
    end
    checks++;
    if (dbl) begin
      errors++;
      $display("FAIL %s we_pulse: got multi-cycle mem_we, required single-cycle pulses", name);
    end
    checks++;
    if (done !== !exp_err || err !== exp_err || core_rst !== exp_err || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s final_status: got done=%b err=%b core_rst=%b rx_ready=%b, required %b %b %b 0",
               name, done, err, core_rst, rx_ready, !exp_err, exp_err, exp_err);
    end
    exp_end = last_acc_cyc + ((!over && n > 0 && !CsumEn) ? 1 : 0);
    checks++;
    if (!end_seen || end_cyc != exp_end) begin
      errors++;
      $display("FAIL %s status_timing: got seen=%b cycle %0d, required cycle %0d",
               name, end_seen, end_cyc, exp_end);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #12;
    checks++;
    if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst: got %b, required 1", core_rst); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", err); end
    checks++;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b, required 0", mem_we); end
    checks++;
    if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready: got %b, required 1", rx_ready); end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_mem_port: got addr %h data %h, required 0 0", mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    byte_q_t d;
    d = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    test_image("back_to_back", d, 0, 1'b0, 1'b0);
    checks++;
    if (obs_data.size() != 2 || obs_data[0] !== 32'h12345678 || obs_data[1] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL directed_words: got %0d writes, required 12345678 then DEADBEEF", obs_data.size());
    end
    test_image("valid_toggle", d, 0, 1'b1, 1'b0);
`ifdef INSTR_LOADER_CSUM_EN
    test_image("csum_bad", d, 0, 1'b0, 1'b1);
`endif
  endtask

  task automatic test_zero_len();
    byte_q_t z;
    z = '{8'h00, 8'h00};
    test_image("zero_len", z, 0, 1'b0, 1'b0);
  endtask

  task automatic test_oversize();
    test_image("oversize_257", make_image(Cap + 1), 0, 1'b0, 1'b0);
    test_image("oversize_rand", make_image(int'($urandom_range(65535, Cap + 2))), 20, 1'b0, 1'b0);
    pulse_start(1'b0);
    #1;
    checks++;
    if (err !== 1'b0 || done !== 1'b0 || core_rst !== 1'b1 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_clears: got err=%b done=%b core_rst=%b rx_ready=%b, required 0 0 1 1",
               err, done, core_rst, rx_ready);
    end
  endtask

  task automatic test_start_abort();
    byte_q_t a;
    byte_q_t b;
    logic [31:0] w;
    a = make_image(3);
    b = make_image(1);
    pulse_start(1'b0);
    send_bytes(a[0:2], 0, 1'b0);
    // A byte offered alongside start must not be taken as LEN_LO.
    pulse_start(1'b1);
    send_bytes(b, 0, 1'b0);
    wait_end();
    w = {b[5], b[4], b[3], b[2]};
    checks++;
    if (obs_addr.size() != 1 || obs_data[0] !== w || obs_addr[0] !== '0 || done !== 1'b1) begin
      errors++;
      $display("FAIL start_abort: got %0d writes data %h done=%b, required 1 write data %h done=1",
               obs_addr.size(), obs_data[0], done, w);
    end
  endtask

  task automatic test_reset_midload();
    byte_q_t d;
    d = make_image(2);
    pulse_start(1'b0);
    send_bytes(d[0:5], 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (core_rst !== 1'b1 || done !== 1'b0 || err !== 1'b0 || mem_we !== 1'b0 ||
        rx_ready !== 1'b1 || mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL midload_reset: got core_rst=%b done=%b err=%b we=%b rdy=%b addr=%h data=%h, required 1 0 0 0 1 0 0",
               core_rst, done, err, mem_we, rx_ready, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_image("after_reset", make_image(3), 25, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 5; k++) begin
      test_image($sformatf("random_%0d", k), make_image(int'($urandom_range(12, 1))),
                 int'($urandom_range(50, 0)), 1'b0, 1'b0);
    end
    test_image("full_memory", make_image(Cap), 10, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_len();
    test_oversize();
    test_start_abort();
    test_reset_midload();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
